// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the skid-buffered pipeline stage: occupancy width and
// the state decode used by assertions and debug.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t;

    // The skid-only encoding is illegal; it decodes as ONE, so any state
    // check must also look at the raw valid bits.
    function automatic pipe_state_t decode_state(input logic main_v, input logic skid_v);
        if (main_v && skid_v) return PS_FULL;
        if (main_v || skid_v) return PS_ONE;
        return PS_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_slot.sv
// One storage slot of the skid stage: an enable-gated data register plus its
// valid flop. A clear returns both to their reset state.
module skid_slot
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_vclr,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Load wins over valid-clear so a pop with a simultaneous refill stays valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data  <= RESET_VALUE;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_data  <= RESET_VALUE;
            r_valid <= 1'b0;
        end else begin
            if (i_load) begin
                r_data <= i_data;
            end
            if (i_load) begin
                r_valid <= 1'b1;
            end else if (i_vclr) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with valid/ready handshake, flush
// and occupancy report. in_ready comes straight from the skid valid flop.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_skid_reg: WIDTH must be > 0");
    end

    logic             w_main_valid;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;
    logic             w_acc;
    logic             w_pop;
    logic             w_main_load;
    logic [WIDTH-1:0] w_main_din;
    logic             w_skid_load;
    pipe_state_t      w_state;

    assign w_acc = in_valid && in_ready;
    assign w_pop = out_valid && out_ready;

    // acc and a valid skid are mutually exclusive, so the skid always has
    // priority as the main-slot source when it holds data.
    assign w_main_load = (w_acc && (!w_main_valid || w_pop)) || (w_skid_valid && w_pop);
    assign w_main_din  = w_skid_valid ? w_skid_data : in_data;
    assign w_skid_load = w_acc && w_main_valid && !w_pop;

    skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clear (flush),
        .i_load  (w_main_load),
        .i_data  (w_main_din),
        .i_vclr  (w_pop),
        .o_data  (out_data),
        .o_valid (w_main_valid)
    );

    skid_slot #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clear (flush),
        .i_load  (w_skid_load),
        .i_data  (in_data),
        .i_vclr  (w_pop),
        .o_data  (w_skid_data),
        .o_valid (w_skid_valid)
    );

    assign in_ready  = !w_skid_valid;
    assign out_valid = w_main_valid;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
    assign w_state   = decode_state(w_main_valid, w_skid_valid);

    a_no_skid_only : assert property (@(posedge clk) disable iff (!reset)
        !w_skid_valid || (w_state == PS_FULL));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed handshake scenarios plus a
// random valid/ready/flush stress against a queue model.
module tb_pipe_skid_reg;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   occupancy;

    pipe_skid_reg #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    int total = 0;
    int bad = 0;
    int held_pre = 0;     // items held during the current cycle
    bit cleared_pre = 1;  // main slot known to hold RESET_VALUE

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; model updated from the handshake rules.
    task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        held_pre  = q.size();
        if (f) begin
            q.delete();
        end else if (v && in_ready && reset) begin
            q.push_back(d);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("occupancy", W'(occupancy), W'(held_pre));
            chk("in_ready", W'(in_ready), W'(held_pre < 2));
            chk("out_valid", W'(out_valid), W'(held_pre > 0));
            chk("skid_only_state", W'(!in_ready && !out_valid), '0);
            if (held_pre == 0 && cleared_pre) chk("out_data_reset", out_data, '0);
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) begin
                    chk("spurious_output", out_data, 'x);
                end else begin
                    chk("out_data", out_data, q.pop_front());
                end
            end
            // Model state for next cycle
            if (flush) cleared_pre = 1;
            else if (in_valid && in_ready) cleared_pre = 0;
        end
    end

    initial begin
        repeat (2) drive(0, '0, 0, 0);
        reset = 1'b1;
        chk("reset_out_data", out_data, '0);
        chk("reset_occupancy", W'(occupancy), '0);
        drive(0, '0, 0, 0);

        // Streaming at full throughput
        drive(1, 64'd32, 1, 0);
        drive(1, 64'd43, 1, 0);
        drive(1, 64'd44, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);

        // Backpressure, held offer of 50, then release
        drive(1, 64'd32, 0, 0);
        drive(1, 64'd43, 0, 0);
        repeat (3) drive(1, 64'd50, 0, 0);
        drive(1, 64'd50, 1, 0);
        drive(1, 64'd50, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);

        // Accept + pop in ONE
        drive(1, 64'd7, 0, 0);
        drive(1, 64'd8, 1, 0);
        drive(0, '0, 1, 0);
        drive(0, '0, 0, 0);

        // Flush in FULL, then flush in ONE with a live accept
        drive(1, 64'd32, 0, 0);
        drive(1, 64'd43, 0, 0);
        drive(1, 64'd99, 1, 1);
        drive(0, '0, 1, 0);
        drive(1, 64'd5, 0, 0);
        drive(1, 64'd99, 1, 1);
        drive(0, '0, 1, 0);

        // Async reset between edges in FULL
        drive(1, 64'd32, 0, 0);
        drive(1, 64'd43, 0, 0);
        drive(0, '0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_occupancy", W'(occupancy), '0);
        chk("async_out_valid", W'(out_valid), '0);
        chk("async_in_ready", W'(in_ready), 64'd1);
        chk("async_out_data", out_data, '0);
        q.delete();
        cleared_pre = 1;
        drive(0, '0, 0, 0);
        reset = 1'b1;
        held_pre = 0;
        drive(0, '0, 0, 0);

        // Random stress
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 8 && q.size() > 0; i++) drive(0, '0, 1, 0);
        drive(0, '0, 1, 0);
        chk("drain_left", W'(q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline-stage register for the pipelined datapath.
- Generalises the plain enabled register into a 2-entry skid-buffered stage with a valid/ready handshake, flush and an occupancy report.
- Sits between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so downstream stalls never create a combinational ready path upstream.
- in_ready is driven purely from flops.

Parameters:
WIDTH, 64, payload width in bits; must be > 0 (elaboration assert).
RESET_VALUE, 0 (WIDTH bits), value driven on out_data after reset and after flush.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream offers in_data.
in_data  input  WIDTH  upstream payload.
in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready at posedge.
out_valid  output  1  out_data holds a valid payload.
out_data  output  WIDTH  payload of the main slot.
out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready at posedge.
flush  input  1  synchronous; discards all held payloads.
occupancy  output  2  number of held payloads, 0..2.

Behaviour:
- Storage: main slot (drives out_data) and skid slot; each has a valid flop.
- States, encoded by the valid bits:
  - EMPTY (0 held)
  - ONE (main only)
  - FULL (main + skid)
  - Skid-only is illegal; the bench asserts it never occurs.
- Combinational outputs:
  - in_ready = !skid_valid
  - out_valid = main_valid
  - occupancy = main_valid + skid_valid
  - All are flop-derived only; no path from out_ready to in_ready.
- Async reset (reset==0): both valids 0, both slots = RESET_VALUE, so out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE. Deassertion is synchronous to the system (not re-synchronised here).
- Transitions at posedge; acc = in_valid&&in_ready, pop = out_valid&&out_ready.
  - EMPTY, acc: main<=in_data -> ONE. No acc: stay EMPTY.
  - ONE, acc&&pop: main<=in_data, stay ONE (full throughput, 1 item/cycle).
  - ONE, acc&&!pop: skid<=in_data -> FULL.
  - ONE, !acc&&pop: -> EMPTY; main data holds its last value.
  - ONE, neither: hold.
  - FULL (in_ready=0, acc impossible), pop: main<=skid -> ONE.
  - FULL, !pop: hold.
- Latency: in_data accepted at edge N appears on out_data with out_valid=1 after edge N (1 cycle) when the stage was EMPTY, or when ONE with a simultaneous pop.
- Ordering: strict FIFO; no drop, no duplication.
- flush=1 at an edge:
  - Both valids <- 0 and both slots <- RESET_VALUE.
  - Overrides simultaneous acc and pop.
  - in_data offered that cycle is discarded; upstream sees the accept (in_ready was 1) and must treat the flush as covering it.
- Data flops not loaded keep their value (enable-gated, no toggling).
- in_valid while in_ready=0: ignored; upstream must hold.
- Reset asserted mid-transfer: immediate clear; no partial state survives.

Decomposition:
- Package pipe_pkg:
  - typedef enum {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_t (for assertions and debug decode)
  - localparam OCC_W = 2
- Sub-module skid_slot #(WIDTH, RESET_VALUE):
  - One WIDTH-bit data register with load enable, plus a valid flop with set/clear.
  - Async active-low reset.
  - Instantiated twice: main and skid.
- The top level holds the next-state/steering logic only.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release with in_valid=0 -> out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE(0).
- Streaming: out_ready=1, offer 32, 43, 44 on consecutive cycles -> out_data 32, 43, 44 on the following cycles, out_valid=1 continuously, in_ready never drops, occupancy=1.
- Backpressure: out_ready=0, offer 32 then 43 -> occupancy 1 then 2, in_ready=0, out_data=32. Hold in_valid with 50 for 3 cycles -> 50 not taken. Set out_ready=1 -> outputs 32, 43, 50 in order, in_ready returns to 1 the cycle after the first pop.
- Simultaneous accept+pop in ONE: main=7, offer 8 with out_ready=1 -> next cycle out_data=8, occupancy stays 1.
- Flush: FULL holding 32, 43, assert flush with in_valid=1, in_data=99, out_ready=1 -> next cycle occupancy=0, out_valid=0, out_data=0, and 99 never emerges.
- Async reset mid-op: in FULL, pulse reset low between edges -> outputs clear immediately without a clock edge. Random valid/ready stress of 1000 cycles against a queue model shows no loss or reorder, and the skid-only state is never reached.
